// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with a double-buffered BCD value and per-slot blanking.
// Define DISP_LZ_SUPPRESS_EN to blank leading zero digits (digit 0 is always shown).
module disp_scan_ctrl #(
  parameter int TICK_DIV  = 25000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        ld_req,
  output logic        ld_ack,
  output logic [3:0]  ledsel,
  output logic [3:0]  digit,
  output logic        frame_start
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [15:0]      active_reg, active_next;
  logic [15:0]      pending_reg, pending_next;
  logic             pend_reg, pend_next;
  logic [3:0]       ledsel_reg, ledsel_next;
  logic [3:0]       digit_reg, digit_next;
  logic             ld_ack_reg, ld_ack_next;
  logic             frame_start_reg, frame_start_next;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       lz_hide;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (idx_reg == 2'd3);

`ifdef DISP_LZ_SUPPRESS_EN
  // A digit is hidden when it and every more significant nibble are zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign lz_hide[gi] = 1'b0;
      end else begin : g_upper
        assign lz_hide[gi] = (active_next[15:4*gi] == '0);
      end
    end
  endgenerate
`else
  assign lz_hide = 4'b0000;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= BLANK;
      cnt_reg         <= '0;
      idx_reg         <= 2'd0;
      active_reg      <= 16'h0000;
      pending_reg     <= 16'h0000;
      pend_reg        <= 1'b0;
      ledsel_reg      <= 4'b1111;
      digit_reg       <= 4'hF;
      ld_ack_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      active_reg      <= active_next;
      pending_reg     <= pending_next;
      pend_reg        <= pend_next;
      ledsel_reg      <= ledsel_next;
      digit_reg       <= digit_next;
      ld_ack_reg      <= ld_ack_next;
      frame_start_reg <= frame_start_next;
    end
  end

  // Outputs are computed from the next (cnt, idx) so the registered values line up with them.
  always_comb begin
    cnt_next         = slot_end ? '0 : cnt_reg + CNT_W'(1);
    idx_next         = slot_end ? idx_reg + 2'd1 : idx_reg;
    pending_next     = ld_req ? bcd_in : pending_reg;
    pend_next        = frame_end ? ld_req : (pend_reg | ld_req);
    active_next      = (frame_end && pend_reg) ? pending_reg : active_reg;
    ld_ack_next      = frame_end && pend_reg;
    frame_start_next = frame_end;
    ledsel_next      = 4'b1111;
    digit_next       = 4'hF;
    state_next       = state_reg;

    case (state_reg)
      BLANK:   state_next = (cnt_next >= BLANK_LIM) ? SHOW : BLANK;
      SHOW:    state_next = (slot_end && (BLANK_LIM != '0)) ? BLANK : SHOW;
      default: state_next = BLANK;
    endcase

    if (state_next == SHOW) begin
      ledsel_next[idx_next] = 1'b0;
      digit_next            = lz_hide[idx_next] ? 4'hF : active_next[4*idx_next +: 4];
    end
  end

  assign ledsel      = ledsel_reg;
  assign digit       = digit_reg;
  assign ld_ack      = ld_ack_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl (TICK_DIV=8, BLANK_CYC=2): directed loads feed a scoreboard of expected acks.
module tb_disp_scan_ctrl;

  localparam int TD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        ld_req = 1'b0;
  logic        ld_ack;
  logic [3:0]  ledsel;
  logic [3:0]  digit;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int pcnt;

  typedef struct {
    logic [15:0] value;
    int          at_edge;
  } sb_t;
  sb_t sb_q[$];

  logic [15:0] exp_active = 16'h0000;

  disp_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .ld_req      (ld_req),
    .ld_ack      (ld_ack),
    .ledsel      (ledsel),
    .digit       (digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // pcnt = number of rising edges since reset release, so cnt = pcnt % TD, idx = (pcnt / TD) % 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) pcnt <= 0;
    else      pcnt <= pcnt + 1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pcnt %0d)", name, act, expv, pcnt);
    end
  endtask

  function automatic logic [7:0] exp_disp(input logic [15:0] v, input int p);
    int          c;
    int          i;
    logic [3:0]  ls;
    logic [3:0]  dg;
    logic [15:0] upper;
    c  = p % TD;
    i  = (p / TD) % 4;
    ls = 4'b1111;
    dg = 4'hF;
    if (c >= BC) begin
      ls[i] = 1'b0;
      upper = v >> (4 * i);
      dg    = upper[3:0];
`ifdef DISP_LZ_SUPPRESS_EN
      if (i > 0 && upper == 16'h0000) dg = 4'hF;
`endif
    end
    return {ls, dg};
  endfunction

  // Monitor: at every frame boundary pop the expected ack; compare all outputs every cycle.
  always @(negedge clk) begin
    logic       boundary;
    logic       exp_ack;
    logic [7:0] e;
    sb_t        s;
    if (!rst) begin
      exp_active = 16'h0000;
    end else begin
      boundary = (pcnt > 0) && (pcnt % FRAME == 0);
      exp_ack  = 1'b0;
      if (boundary && sb_q.size() > 0 && sb_q[0].at_edge == pcnt) begin
        s          = sb_q.pop_front();
        exp_active = s.value;
        exp_ack    = 1'b1;
        $display("ack expected for %h at pcnt %0d, ld_ack=%b", s.value, pcnt, ld_ack);
      end
      chk("ld_ack", {15'd0, ld_ack}, {15'd0, exp_ack});
      chk("frame_start", {15'd0, frame_start}, {15'd0, boundary});
      e = exp_disp(exp_active, pcnt);
      chk("ledsel", {12'd0, ledsel}, {12'd0, e[7:4]});
      chk("digit", {12'd0, digit}, {12'd0, e[3:0]});
    end
  end

  task automatic wait_to(input int p);
    int guard = 0;
    while (pcnt != p && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_to: got pcnt %0d expected %0d", pcnt, p);
    end
  endtask

  // Drive ld_req so that it is sampled on rising edge number p.
  task automatic load(input logic [15:0] v, input int p, input bit push, input int ack_at);
    wait_to(p - 1);
    ld_req = 1'b1;
    bcd_in = v;
    if (push) sb_q.push_back('{v, ack_at});
    $display("load %h on edge %0d", v, p);
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Mid-slot asynchronous reset while a load is pending.
    load(16'h1111, 5, 1'b0, 0);
    wait_to(13);
    #2 rst = 1'b0;
    #1;
    chk("rst_ledsel", {12'd0, ledsel}, 16'h000F);
    chk("rst_digit", {12'd0, digit}, 16'h000F);
    chk("rst_ld_ack", {15'd0, ld_ack}, 16'h0000);
    chk("rst_frame_start", {15'd0, frame_start}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Scan sequence with 0x5040, shown in frame starting at edge 32.
    load(16'h5040, 3, 1'b1, 32);
    wait_to(42);
    chk("scan_idx1_ledsel", {12'd0, ledsel}, 16'h000D);
    chk("scan_idx1_digit", {12'd0, digit}, 16'h0004);
    wait_to(63);
    chk("scan_idx3_ledsel", {12'd0, ledsel}, 16'h0007);
    chk("scan_idx3_digit", {12'd0, digit}, 16'h0005);

    // Load at idx=1, cnt=3 of frame 64; acked at the next frame start.
    load(16'h0720, 76, 1'b1, 96);
    wait_to(96);
    chk("hs_ack", {15'd0, ld_ack}, 16'h0001);
    chk("hs_frame_start", {15'd0, frame_start}, 16'h0001);
    wait_to(98);
    chk("hs_digit0", {12'd0, digit}, 16'h0000);
    chk("hs_ledsel0", {12'd0, ledsel}, 16'h000E);

    // Latest wins: only 0x0120 is acked.
    load(16'h0024, 100, 1'b0, 0);
    load(16'h0120, 110, 1'b1, 128);

    // Boundary collision: 0x0006 acked at 160, 0x0002 written on that edge and acked at 192.
    load(16'h0006, 140, 1'b1, 160);
    load(16'h0002, 160, 1'b1, 192);

    load(16'h0000, 200, 1'b1, 224);
    load(16'h0024, 230, 1'b1, 256);

    wait_to(290);
    chk("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the four-digit seven-segment display. It holds a double-buffered 16-bit BCD value and time-slices the digits: it selects one nibble per slot and drives the active-low digit enables. Each slot starts with a blanking interval so the previous digit does not ghost. Its `digit` output feeds the BCD-to-segment decoder, and `ledsel` drives the anode enables directly.

## Interface
- `TICK_DIV`, default 25000: `clk` cycles per digit slot; legal range ≥ 2.
- `BLANK_CYC`, default 500: blanked cycles at the start of each slot; legal range 0 ≤ BLANK_CYC < TICK_DIV.
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `bcd_in`, input, 16: new display value; `[15:12]` is the most significant digit (index 3), `[3:0]` is digit 0.
- `ld_req`, input, 1: single-cycle load strobe; `bcd_in` is sampled on the same edge.
- `ld_ack`, output, 1: one-cycle pulse when a pending value becomes the active value.
- `ledsel`, output, 4: active-low digit enables; `1110` selects digit 0 and `0111` selects digit 3.
- `digit`, output, 4: nibble for the selected digit; `4'hF` means blank.
- `frame_start`, output, 1: one-cycle pulse at the start of each digit-0 slot.

## Operation
- State is held in these registers:
  - `cnt`: 0..TICK_DIV-1.
  - `idx`: 0..3.
  - `active[15:0]`, `pending[15:0]`, `pend`.
  - Scan FSM with states `BLANK` and `SHOW`.
- Scan sequence:
  - `cnt` increments every cycle.
  - At `cnt == TICK_DIV-1`, `cnt` wraps to 0 and `idx` advances modulo 4.
  - FSM is in `BLANK` when `cnt < BLANK_CYC`, otherwise `SHOW`.
- Outputs in `BLANK`: `ledsel = 1111`, `digit = F`.
- Outputs in `SHOW`: `ledsel` has bit `idx` low and all others high; `digit = active[4*idx+3 : 4*idx]`.
- Nibble values A–E pass through unchanged; the downstream decoder shows them as off.
- Load handshake:
  - `ld_req` loads `pending <= bcd_in` and sets `pend`.
  - A second `ld_req` while `pend = 1` overwrites `pending` (latest value wins). No `ld_ack` is issued for the overwritten value.
- Frame boundary is the edge where `idx` goes 3→0 with `cnt` wrapping. On that edge:
  - If `pend = 1`: `active <= pending`, `pend` clears, and `ld_ack` pulses.
  - `frame_start` pulses regardless of `pend`.
- `ld_req` on the boundary edge:
  - The value already in `pending` (if any) transfers to `active`.
  - The new `bcd_in` is written to `pending` and `pend` stays 1 (or becomes 1).
  - The new value transfers at the next boundary.
- `active` never changes mid-frame.
- Reset (asynchronous, any time, including mid-frame):
  - `cnt = 0`, `idx = 0`, FSM in `BLANK`.
  - `active = 0`, `pending = 0`, `pend = 0`.
  - `ledsel = 1111`, `digit = F`, `ld_ack = 0`, `frame_start = 0`.

## Timing
- All outputs are registered and updated on the same edge as `cnt`/`idx`, so outputs in any cycle match the current `(cnt, idx)`.
- Slot length is TICK_DIV cycles; frame length is 4·TICK_DIV cycles.
- After `rst` deasserts, the first slot is digit 0 starting at `cnt = 0`. No `frame_start` pulse is issued for this first slot.
- `ld_ack` and `frame_start` are high in the cycle where `cnt = 0` and `idx = 0` (first cycle of the new frame). The new `active` value is first visible on `digit` at `cnt = BLANK_CYC` of that slot.
- Load latency: from `ld_req` to `ld_ack` is 1 to 4·TICK_DIV cycles.
- With BLANK_CYC = 0, `ledsel` is never `1111` except in reset.

## Configuration
- `DISP_LZ_SUPPRESS_EN` defined: leading-zero suppression is enabled.
  - Digits above the most significant nonzero nibble of `active` output `digit = F`.
  - `ledsel` still follows the normal scan.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
- `DISP_LZ_SUPPRESS_EN` undefined: all four nibbles are shown verbatim.

## Test plan
- Reset check (TICK_DIV = 8, BLANK_CYC = 2): assert `rst = 0` mid-slot → `ledsel = 1111`, `digit = F`, `ld_ack = 0`, `frame_start = 0` immediately, without waiting for a clock edge. Release → digit-0 slot starts with `cnt = 0`.
- Scan sequence: `ld_req` with `0x5040` → per slot, 2 cycles of `1111`/`F`, then 6 cycles of `1110`/`0`, `1101`/`4`, `1011`/`0`, `0111`/`5`. `frame_start` recurs every 32 cycles.
- Load handshake: `ld_req` with `0x0720` at `idx = 1`, `cnt = 3` → `ld_ack` is high only at the next `idx = 0`, `cnt = 0`, coincident with `frame_start`. `digit` shows `0` at `idx = 0`, `cnt = 2`.
- Latest wins: `ld_req` `0x0024` then `ld_req` `0x0120` in the same frame → exactly one `ld_ack`, and the display shows 0120.
- Boundary collision: with `pend = 1` (`0x0006`), `ld_req` `0x0002` on the boundary edge → 0006 is shown this frame with `ld_ack`; 0002 is shown next frame with a second `ld_ack`.
- With `DISP_LZ_SUPPRESS_EN`: `active = 0x0024` → digits 3 and 2 give `F`, digit 1 gives `2`, digit 0 gives `4`. `active = 0x0000` → only digit 0 gives `0`.
